// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : draw_sequencer
// Purpose  : Frame-level draw scheduler. Locks to VGA vertical sync and walks
//            room, player, each live enemy slot and HUD, with room-transition
//            frames and a game-over screen.
// Revision : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
  parameter int NUM_ENEMIES  = 5,
  parameter int HEALTH_W     = 3,
  parameter int TRANS_FRAMES = 30,
  localparam int IDX_W       = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   VGA_VS,
  input  logic                   Start,
  input  logic                   NextRoom,
  input  logic                   Done,
  input  logic                   DrawRoomDone,
  input  logic                   DrawHudDone,
  input  logic [HEALTH_W-1:0]    PlayerHealth,
  input  logic [NUM_ENEMIES-1:0] EnemyAlive,
  output logic [2:0]             Draw_state,
  output logic                   DrawRoomEN,
  output logic                   DrawHudEN,
  output logic [IDX_W-1:0]       EnemyIdx,
  output logic                   FrameDone
);

  localparam int CNT_W = (TRANS_FRAMES > 1) ? $clog2(TRANS_FRAMES) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TITLE    = 4'd1,
    S_SYNC_HI  = 4'd2,
    S_SYNC_LO  = 4'd3,
    S_ROOM     = 4'd4,
    S_PLAYER   = 4'd5,
    S_ENEMY    = 4'd6,
    S_HUD      = 4'd7,
    S_TRANS    = 4'd8,
    S_GAMEOVER = 4'd9
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_vs_d;
  logic             r_start_d;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_frame_done;
  logic             w_vs_fall;
  logic             w_start_rise;
  logic             w_first_found;
  logic [IDX_W-1:0] w_first_idx;
  logic             w_next_found;
  logic [IDX_W-1:0] w_next_idx;

  // Layer select code presented to the pixel datapath for each internal state
  function automatic logic [2:0] state_code(input state_t s);
    case (s)
      S_TITLE:    return 3'd1;
      S_ROOM:     return 3'd2;
      S_PLAYER:   return 3'd3;
      S_ENEMY:    return 3'd4;
      S_HUD:      return 3'd5;
      S_TRANS:    return 3'd6;
      S_GAMEOVER: return 3'd7;
      default:    return 3'd0;
    endcase
  endfunction

  // Edge detects and enemy slot search (lowest live slot, next live slot above current)
  always_comb begin
    w_vs_fall     = r_vs_d & ~VGA_VS;
    w_start_rise  = Start & ~r_start_d;
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    // Scanning downward leaves the lowest qualifying slot as the final winner
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (EnemyAlive[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_W'(i);
        if (i > int'(EnemyIdx)) begin
          w_next_found = 1'b1;
          w_next_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Next-state logic; health loss takes priority over everything in play states
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pending;
    w_idx_nxt    = EnemyIdx;
    w_frame_done = 1'b0;

    if (NextRoom && !(r_state inside {S_IDLE, S_TITLE, S_GAMEOVER, S_TRANS}))
      w_pend_nxt = 1'b1;

    case (r_state)
      S_IDLE:    if (!VGA_VS) w_state_nxt = S_TITLE;
      S_TITLE:   if (Start) w_state_nxt = S_SYNC_HI;
      S_SYNC_HI: if (VGA_VS) w_state_nxt = S_SYNC_LO;
      S_SYNC_LO: begin
        if (!VGA_VS) begin
          if (r_pending) begin
            w_state_nxt = S_TRANS;
            w_cnt_nxt   = CNT_W'(TRANS_FRAMES - 1);
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_ROOM;
          end
        end
      end
      S_ROOM:    if (DrawRoomDone) w_state_nxt = S_PLAYER;
      S_PLAYER: begin
        if (Done) begin
          w_state_nxt = w_first_found ? S_ENEMY : S_HUD;
          w_idx_nxt   = w_first_idx;
        end
      end
      S_ENEMY: begin
        if (Done) begin
          w_state_nxt = w_next_found ? S_ENEMY : S_HUD;
          w_idx_nxt   = w_next_idx;
        end
      end
      S_HUD: begin
        if (DrawHudDone) begin
          w_state_nxt  = S_SYNC_HI;
          w_frame_done = 1'b1;
        end
      end
      S_TRANS: begin
        if (w_vs_fall) begin
          if (r_cnt == '0) w_state_nxt = S_ROOM;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      S_GAMEOVER: if (w_start_rise) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    if ((PlayerHealth == '0) && !(r_state inside {S_IDLE, S_TITLE, S_GAMEOVER})) begin
      w_state_nxt  = S_GAMEOVER;
      w_pend_nxt   = 1'b0;
      w_frame_done = 1'b0;
    end
  end

  // State register with Moore outputs registered from the next state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_vs_d     <= 1'b0;
      r_start_d  <= 1'b0;
      Draw_state <= 3'd0;
      DrawRoomEN <= 1'b0;
      DrawHudEN  <= 1'b0;
      EnemyIdx   <= '0;
      FrameDone  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pend_nxt;
      r_vs_d     <= VGA_VS;
      r_start_d  <= Start;
      Draw_state <= state_code(w_state_nxt);
      DrawRoomEN <= (w_state_nxt == S_ROOM);
      DrawHudEN  <= (w_state_nxt == S_HUD);
      EnemyIdx   <= (w_state_nxt == S_ENEMY) ? w_idx_nxt : '0;
      FrameDone  <= w_frame_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sequencer
// Purpose  : Scoreboard bench for draw_sequencer. Stimulus queues the expected
//            output after every change; a monitor pops on each output change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_sequencer;

  localparam int NUM_ENEMIES  = 5;
  localparam int HEALTH_W     = 3;
  localparam int TRANS_FRAMES = 3;
  localparam int IDX_W        = 3;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   VGA_VS;
  logic                   Start;
  logic                   NextRoom;
  logic                   Done;
  logic                   DrawRoomDone;
  logic                   DrawHudDone;
  logic [HEALTH_W-1:0]    PlayerHealth;
  logic [NUM_ENEMIES-1:0] EnemyAlive;
  logic [2:0]             Draw_state;
  logic                   DrawRoomEN;
  logic                   DrawHudEN;
  logic [IDX_W-1:0]       EnemyIdx;
  logic                   FrameDone;

  typedef struct packed {
    logic [2:0]       st;
    logic [IDX_W-1:0] idx;
    logic             fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  draw_sequencer #(
    .NUM_ENEMIES (NUM_ENEMIES),
    .HEALTH_W    (HEALTH_W),
    .TRANS_FRAMES(TRANS_FRAMES)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VGA_VS      (VGA_VS),
    .Start       (Start),
    .NextRoom    (NextRoom),
    .Done        (Done),
    .DrawRoomDone(DrawRoomDone),
    .DrawHudDone (DrawHudDone),
    .PlayerHealth(PlayerHealth),
    .EnemyAlive  (EnemyAlive),
    .Draw_state  (Draw_state),
    .DrawRoomEN  (DrawRoomEN),
    .DrawHudEN   (DrawHudEN),
    .EnemyIdx    (EnemyIdx),
    .FrameDone   (FrameDone)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input int st, input int idx, input logic fd);
    exp_t e;
    e.st  = 3'(st);
    e.idx = IDX_W'(idx);
    e.fd  = fd;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every change of the output bundle consumes one expected entry
  initial begin
    logic [8:0] prev;
    logic [8:0] cur;
    exp_t e;
    prev = '0;
    wait (mon_en);
    forever begin
      @(negedge CLK);
      cur = {Draw_state, EnemyIdx, FrameDone, DrawRoomEN, DrawHudEN};
      if (cur !== prev) begin
        prev = cur;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got state=%0d idx=%0d fd=%0b room=%0b hud=%0b, none expected",
                   Draw_state, EnemyIdx, FrameDone, DrawRoomEN, DrawHudEN);
        end else begin
          e = q.pop_front();
          if (Draw_state !== e.st || EnemyIdx !== e.idx || FrameDone !== e.fd ||
              DrawRoomEN !== (e.st == 3'd2) || DrawHudEN !== (e.st == 3'd5)) begin
            errors++;
            $display("FAIL output_seq: got state=%0d idx=%0d fd=%0b room=%0b hud=%0b, expected state=%0d idx=%0d fd=%0b room=%0b hud=%0b",
                     Draw_state, EnemyIdx, FrameDone, DrawRoomEN, DrawHudEN,
                     e.st, e.idx, e.fd, (e.st == 3'd2), (e.st == 3'd5));
          end
        end
      end
    end
  end

  initial begin
    RESET = 1'b1; VGA_VS = 1'b1; Start = 1'b0; NextRoom = 1'b0; Done = 1'b0;
    DrawRoomDone = 1'b0; DrawHudDone = 1'b0; PlayerHealth = 3'd5; EnemyAlive = 5'b01000;
    tick(3);
    check("reset_state", int'(Draw_state), 0);
    RESET = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Reach ENEMY slot 3, then reset asynchronously
    expect_out(1, 0, 0); VGA_VS = 1'b0; tick(2);
    expect_out(0, 0, 0); Start = 1'b1; tick(1); Start = 1'b0; tick(1);
    VGA_VS = 1'b1; tick(2);
    expect_out(2, 0, 0); VGA_VS = 1'b0; tick(2);
    expect_out(3, 0, 0); DrawRoomDone = 1'b1; tick(1); DrawRoomDone = 1'b0; tick(2);
    expect_out(4, 3, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    check("pre_reset_idx", int'(EnemyIdx), 3);
    expect_out(0, 0, 0);
    VGA_VS = 1'b1;
    #2 RESET = 1'b1;
    #1;
    check("async_reset_state", int'(Draw_state), 0);
    check("async_reset_idx", int'(EnemyIdx), 0);
    tick(2);
    RESET = 1'b0;
    tick(2);

    // Full frame with enemies in slots 0, 2, 4 plus stray pulses
    expect_out(1, 0, 0); VGA_VS = 1'b0; tick(2);
    expect_out(0, 0, 0); Start = 1'b1; tick(1); Start = 1'b0; tick(1);
    VGA_VS = 1'b1; tick(2);
    EnemyAlive = 5'b10101;
    expect_out(2, 0, 0); VGA_VS = 1'b0; tick(2);
    Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    check("done_in_room_ignored", int'(Draw_state), 2);
    expect_out(3, 0, 0); DrawRoomDone = 1'b1; tick(1); DrawRoomDone = 1'b0; tick(2);
    DrawHudDone = 1'b1; tick(1); DrawHudDone = 1'b0; tick(2);
    expect_out(4, 0, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    expect_out(4, 2, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    expect_out(4, 4, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    expect_out(5, 0, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    expect_out(0, 0, 1); expect_out(0, 0, 0);
    DrawHudDone = 1'b1; tick(1); DrawHudDone = 1'b0; tick(3);

    // Frame with no live enemies and a room request during PLAYER
    EnemyAlive = 5'b00000;
    VGA_VS = 1'b1; tick(2);
    expect_out(2, 0, 0); VGA_VS = 1'b0; tick(2);
    expect_out(3, 0, 0); DrawRoomDone = 1'b1; tick(1); DrawRoomDone = 1'b0; tick(2);
    NextRoom = 1'b1; tick(1); NextRoom = 1'b0; tick(2);
    expect_out(5, 0, 0); Done = 1'b1; tick(1); Done = 1'b0; tick(2);
    expect_out(0, 0, 1); expect_out(0, 0, 0);
    DrawHudDone = 1'b1; tick(1); DrawHudDone = 1'b0; tick(3);

    // Transition frames: held for exactly TRANS_FRAMES falling edges
    VGA_VS = 1'b1; tick(2);
    expect_out(6, 0, 0); VGA_VS = 1'b0; tick(2);
    for (int k = 0; k < TRANS_FRAMES - 1; k++) begin
      VGA_VS = 1'b1; tick(2);
      VGA_VS = 1'b0; tick(2);
    end
    check("trans_held", int'(Draw_state), 6);
    VGA_VS = 1'b1; tick(2);
    expect_out(2, 0, 0); VGA_VS = 1'b0; tick(3);

    // Health loss coincident with DrawRoomDone, then game-over exit
    expect_out(7, 0, 0);
    PlayerHealth = 3'd0; DrawRoomDone = 1'b1; Start = 1'b1; tick(1);
    DrawRoomDone = 1'b0; tick(5);
    check("gameover_start_held", int'(Draw_state), 7);
    Start = 1'b0; tick(2);
    check("gameover_start_low", int'(Draw_state), 7);
    expect_out(0, 0, 0); expect_out(1, 0, 0);
    Start = 1'b1; tick(1); Start = 1'b0; PlayerHealth = 3'd4; tick(4);
    check("title_after_gameover", int'(Draw_state), 1);

    for (int c = 0; c < 50 && q.size() != 0; c++) tick(1);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
